// File: rtl/io_map_pkg.sv
// IO window map shared by the LED/switch bridge and its debouncer.
package io_map_pkg;

    localparam int unsigned IO_DATA_W = 24;
    localparam int unsigned SW_LO_W   = 16;
    localparam int unsigned SW_HI_W   = 8;

    localparam logic [1:0] LED_LO_OFF = 2'd0;
    localparam logic [1:0] LED_HI_OFF = 2'd2;
    localparam logic [1:0] SW_LO_OFF  = 2'd0;
    localparam logic [1:0] SW_HI_OFF  = 2'd2;

endpackage

// File: rtl/switch_debouncer.sv
// Synchronises raw switches, samples them on a slow tick and accepts a level
// only after STABLE_SAMPLES consecutive equal samples.
module switch_debouncer #(
    parameter int unsigned WIDTH          = 24,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned STABLE_SAMPLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] sw,
    output logic             sw_changed
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned S     = STABLE_SAMPLES;

    logic [WIDTH-1:0]        sync1;
    logic [WIDTH-1:0]        sync2;
    logic [CNT_W-1:0]        cnt;
    logic                    tick;
    logic                    tick_q;
    logic [WIDTH-1:0][S-1:0] hist;
    logic [WIDTH-1:0]        sw_next;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Free-running sample tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + CNT_W'(1);
            tick_q <= tick;
        end
    end

    // Shift one synchronised sample per bit into its history on each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (tick) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                hist[i] <= {hist[i][S-2:0], sync2[i]};
            end
        end
    end

    // Accept a new level only when the whole history agrees, the cycle after a tick.
    always_comb begin
        sw_next = sw;
        if (tick_q) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (&hist[i]) begin
                    sw_next[i] = 1'b1;
                end else if (~|hist[i]) begin
                    sw_next[i] = 1'b0;
                end
            end
        end
    end

    // Debounced level and its one-cycle change pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw         <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw         <= sw_next;
            sw_changed <= (sw_next != sw);
        end
    end

endmodule

// File: rtl/io_led_switch_bridge.sv
// Memory-mapped IO responder: LED register for CPU stores, debounced switch reads.
module io_led_switch_bridge
    import io_map_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned STABLE_SAMPLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        led_ctrl,
    input  logic        switch_ctrl,
    input  logic        io_write,
    input  logic        io_read,
    input  logic [1:0]  addr_low,
    input  logic [23:0] io_wdata,
    output logic [23:0] io_rdata,
    input  logic [23:0] switch_in,
    output logic [23:0] led_out,
    output logic        sw_changed
);

    logic [IO_DATA_W-1:0] sw;
    logic                 unused_wdata;

    // Upper store byte never maps to any LED field.
    assign unused_wdata = ^io_wdata[23:16];

    switch_debouncer #(
        .WIDTH          (IO_DATA_W),
        .TICK_DIV       (TICK_DIV),
        .STABLE_SAMPLES (STABLE_SAMPLES)
    ) u_debouncer (
        .clk        (clk),
        .rst        (rst),
        .raw        (switch_in),
        .sw         (sw),
        .sw_changed (sw_changed)
    );

    // LED register: halfword store at offset 0, byte store at offset 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= '0;
        end else if (led_ctrl && io_write) begin
            case (addr_low)
                LED_LO_OFF: led_out[15:0]  <= io_wdata[15:0];
                LED_HI_OFF: led_out[23:16] <= io_wdata[7:0];
                default:    ;
            endcase
        end
    end

    // Same-cycle switch read mux; an LED/switch double decode reads as zero.
    always_comb begin
        io_rdata = '0;
        if (switch_ctrl && io_read && !led_ctrl) begin
            case (addr_low)
                SW_LO_OFF: io_rdata = IO_DATA_W'(sw[SW_LO_W-1:0]);
                SW_HI_OFF: io_rdata = IO_DATA_W'(sw[SW_LO_W +: SW_HI_W]);
                default:   io_rdata = '0;
            endcase
        end
    end

endmodule
